// File: rtl/conv_pkg.sv
// ----------------------------------------------------------------------------
// conv_pkg
// Shared types and constants for the CONV multiply-accumulate sequencer.
//   state_t      : sequencer states (2-bit encoding)
//   *_W_DEF      : default operand, product and tap-count widths
//   sat_hi/lo    : signed saturation limits for a given width
//   SAT_*_DEF    : saturation limits at the default product width
// ----------------------------------------------------------------------------
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DATA_W_DEF = 12;
    localparam int PROD_W_DEF = 24;
    localparam int LEN_W_DEF  = 8;

    // Largest / smallest value representable in a w-bit signed field.
    function automatic longint sat_hi(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_lo(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    localparam longint SAT_HI_DEF = sat_hi(PROD_W_DEF);
    localparam longint SAT_LO_DEF = sat_lo(PROD_W_DEF);

endpackage

// File: rtl/conv_tag_pipe.sv
// ----------------------------------------------------------------------------
// conv_tag_pipe
// DEPTH-deep valid shift register that follows operands through the external
// multiplier, so a tag leaves exactly when the matching product is valid.
// DEPTH=0 degenerates to a wire (always empty).
//   clk     : system clock
//   reset   : asynchronous active-low clear
//   tag_in  : tag entering the pipe this cycle
//   tag_out : tag leaving the pipe (product valid)
//   empty   : no tag anywhere in the pipe
// ----------------------------------------------------------------------------
module conv_tag_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic tag_in,
    output logic tag_out,
    output logic empty
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign tag_out = tag_in;
            assign empty   = 1'b1;
        end else begin : g_pipe
            logic [DEPTH-1:0] stages;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    stages <= '0;
                end else begin
                    stages[0] <= tag_in;
                    for (int i = 1; i < DEPTH; i++) begin
                        stages[i] <= stages[i-1];
                    end
                end
            end

            assign tag_out = stages[DEPTH-1];
            assign empty   = ~|stages;
        end
    endgenerate

endmodule

// File: rtl/conv_mac_ctrl.sv
// ----------------------------------------------------------------------------
// conv_mac_ctrl
// Sequences the single-product CONV multiplier as an N-tap signed MAC.
// A start command latches the tap count; sample/coefficient pairs are
// registered onto mul_a/mul_b, products returning on mul_p are accumulated,
// and one result is offered on the out_valid/out_ready port.
// Optional feature: define CONV_MAC_SAT_EN to saturate the result to signed
// PROD_W instead of wrapping.
//   clk, reset            : clock, asynchronous active-low reset
//   start, len, busy      : command strobe, tap count, not-idle flag
//   in_valid/in_ready     : operand pair handshake (in_data0, in_data1)
//   mul_a, mul_b, mul_p   : registered operands to CONV, product from CONV
//   out_valid/out_ready   : result handshake (out_data)
// ----------------------------------------------------------------------------
module conv_mac_ctrl
    import conv_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PROD_W  = PROD_W_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int MUL_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [LEN_W-1:0]         len,
    output logic                     busy,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data0,
    input  logic signed [DATA_W-1:0] in_data1,
    output logic signed [DATA_W-1:0] mul_a,
    output logic signed [DATA_W-1:0] mul_b,
    input  logic signed [PROD_W-1:0] mul_p,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [PROD_W-1:0] out_data
);

    // Wide enough that 2^LEN_W-1 full-scale products never overflow.
    localparam int ACC_W = PROD_W + LEN_W;

    state_t                   state, state_nxt;
    logic [LEN_W-1:0]         len_q;
    logic [LEN_W-1:0]         cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [PROD_W-1:0] result;
    logic                     op_vld;
    logic                     tag_exit;
    logic                     pipe_empty;
    logic                     accept;
    logic                     last_beat;
    logic                     drained;

    assign busy      = (state != IDLE);
    assign in_ready  = (state == FEED);
    assign out_valid = (state == DONE);

    assign accept    = in_valid && in_ready;
    assign last_beat = accept && (cnt == len_q - LEN_W'(1));
    // op_vld marks a pair sitting in mul_a/mul_b; the pipe then delays it to
    // line up with mul_p. The final add happens on the edge the tag exits,
    // so "drained" only goes true the cycle after that add.
    assign drained   = !op_vld && pipe_empty;

    conv_tag_pipe #(
        .DEPTH (MUL_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (op_vld),
        .tag_out (tag_exit),
        .empty   (pipe_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt; no latch.
        state_nxt = state;
        case (state)
            IDLE:    if (start)     state_nxt = (len != '0) ? FEED : DONE;
            FEED:    if (last_beat) state_nxt = DRAIN;
            DRAIN:   if (drained)   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

`ifdef CONV_MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_hi(PROD_W));
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_lo(PROD_W));

    always_comb begin
        if (acc > SAT_HI) begin
            result = SAT_HI[PROD_W-1:0];
        end else if (acc < SAT_LO) begin
            result = SAT_LO[PROD_W-1:0];
        end else begin
            result = acc[PROD_W-1:0];
        end
    end
`else
    assign result = acc[PROD_W-1:0];
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q    <= '0;
            cnt      <= '0;
            acc      <= '0;
            op_vld   <= 1'b0;
            mul_a    <= '0;
            mul_b    <= '0;
            out_data <= '0;
        end else begin
            op_vld <= accept;

            if (state == IDLE && start) begin
                len_q <= len;
                cnt   <= '0;
                acc   <= '0;
                if (len == '0) begin
                    out_data <= '0;
                end
            end

            if (accept) begin
                mul_a <= in_data0;
                mul_b <= in_data1;
                cnt   <= cnt + LEN_W'(1);
            end

            // Size cast of a signed value sign-extends the product.
            if (tag_exit) begin
                acc <= acc + ACC_W'(mul_p);
            end

            if (state == DRAIN && drained) begin
                out_data <= result;
            end
        end
    end

endmodule

// File: tb/tb_conv_mac_ctrl.sv
// ----------------------------------------------------------------------------
// tb_conv_mac_ctrl
// Directed bench for conv_mac_ctrl with a one-cycle registered CONV model.
// Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_conv_mac_ctrl;

    localparam int DATA_W  = 12;
    localparam int PROD_W  = 24;
    localparam int LEN_W   = 8;
    localparam int MUL_LAT = 1;
    localparam int BOUND   = 600;

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic                     start = 1'b0;
    logic [LEN_W-1:0]         len = '0;
    logic                     busy;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data0 = '0;
    logic signed [DATA_W-1:0] in_data1 = '0;
    logic signed [DATA_W-1:0] mul_a;
    logic signed [DATA_W-1:0] mul_b;
    logic signed [PROD_W-1:0] mul_p = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic signed [PROD_W-1:0] out_data;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // CONV model: one register stage after the operand registers.
    always @(posedge clk) mul_p <= mul_a * mul_b;

    conv_mac_ctrl #(
        .DATA_W  (DATA_W),
        .PROD_W  (PROD_W),
        .LEN_W   (LEN_W),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Pulse start for one edge; returns on the falling edge after it.
    task automatic start_op(input int l);
        start = 1'b1;
        len   = LEN_W'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present a pair and hold it until accepted; returns on the falling edge
    // after the accepting edge with in_valid still high.
    task automatic feed_beat(input int a, input int b);
        int waited = 0;
        in_data0 = DATA_W'(a);
        in_data1 = DATA_W'(b);
        in_valid = 1'b1;
        while (!in_ready && waited < BOUND) begin
            @(negedge clk);
            waited++;
        end
        check("feed_timeout", (waited < BOUND), 1);
        @(negedge clk);
    endtask

    // Wait for out_valid; lat counts edges after the last accepting edge.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < BOUND) begin
            @(negedge clk);
            lat++;
        end
        check("result_timeout", out_valid, 1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hs_idle_busy", busy, 0);
        check("hs_idle_valid", out_valid, 0);
    endtask

    initial begin
        int lat;
        int accepted;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_b", mul_b, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        reset = 1'b1;
        @(negedge clk);

        // len=3, (3,2) x3 back-to-back -> 18, out_valid 3 edges after last accept
        start_op(3);
        check("t1_busy_start", busy, 1);
        check("t1_in_ready", in_ready, 1);
        feed_beat(3, 2);
        feed_beat(3, 2);
        check("t1_busy_mid", busy, 1);
        feed_beat(3, 2);
        in_valid = 1'b0;
        check("t1_ready_drop", in_ready, 0);
        wait_result(lat);
        check("t1_latency", lat, MUL_LAT + 2);
        check("t1_out_data", out_data, 18);
        check("t1_busy_done", busy, 1);
        handshake();

        // len=4 with gaps: (5,-7),(-1,-1),(100,3),(0,9) -> 266
        start_op(4);
        accepted = 0;
        in_data0 = 12'sd5;   in_data1 = -12'sd7; in_valid = 1'b1;
        if (in_ready) accepted++;
        @(negedge clk); in_valid = 1'b0; @(negedge clk);
        in_data0 = -12'sd1;  in_data1 = -12'sd1; in_valid = 1'b1;
        if (in_ready) accepted++;
        @(negedge clk); in_valid = 1'b0; @(negedge clk);
        in_data0 = 12'sd100; in_data1 = 12'sd3;  in_valid = 1'b1;
        if (in_ready) accepted++;
        @(negedge clk); in_valid = 1'b0; @(negedge clk);
        in_data0 = 12'sd0;   in_data1 = 12'sd9;  in_valid = 1'b1;
        if (in_ready) accepted++;
        @(negedge clk); in_valid = 1'b0;
        check("t2_ready_after4", in_ready, 0);
        @(negedge clk);
        in_data0 = 12'sd99;  in_data1 = 12'sd99; in_valid = 1'b1;
        if (in_ready) accepted++;
        @(negedge clk); in_valid = 1'b0;
        check("t2_accepted", accepted, 4);
        check("t2_mul_a_hold", mul_a, 0);
        check("t2_mul_b_hold", mul_b, 9);
        wait_result(lat);
        check("t2_out_data", out_data, 266);
        handshake();

        // len=0 -> immediate zero result, no in_ready
        start_op(0);
        check("t3_out_valid", out_valid, 1);
        check("t3_out_data", out_data, 0);
        check("t3_in_ready", in_ready, 0);
        handshake();

        // len=255, all (-2048,-2048)
        start_op(255);
        accepted = 0;
        in_data0 = -12'sd2048;
        in_data1 = -12'sd2048;
        in_valid = 1'b1;
        for (int i = 0; i < BOUND && accepted < 255; i++) begin
            if (in_ready) accepted++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("t4_accepted", accepted, 255);
        wait_result(lat);
`ifdef CONV_MAC_SAT_EN
        check("t4_out_data_sat", out_data, 8388607);
`else
        check("t4_out_data_wrap", out_data, -4194304);
`endif
        handshake();

        // Hold out_ready low 5 cycles, pulse start in DONE: (7,-3),(-4,5) -> -41
        start_op(2);
        feed_beat(7, -3);
        feed_beat(-4, 5);
        in_valid = 1'b0;
        wait_result(lat);
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_valid", out_valid, 1);
            check("t5_hold_data", out_data, -41);
            start = (i == 2);
            len   = 8'd5;
            @(negedge clk);
        end
        start = 1'b0;
        check("t5_still_done", out_valid, 1);
        handshake();
        check("t5_start_ignored", in_ready, 0);

        // Reset mid-operation after 2 of 5 beats
        start_op(5);
        feed_beat(10, 10);
        feed_beat(10, 10);
        in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_in_ready", in_ready, 0);
        check("t6_rst_mul_a", mul_a, 0);
        check("t6_rst_mul_b", mul_b, 0);
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_out_data", out_data, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6_post_busy", busy, 0);
        check("t6_post_valid", out_valid, 0);
        start_op(1);
        feed_beat(3, 2);
        in_valid = 1'b0;
        wait_result(lat);
        check("t6_out_data", out_data, 6);
        handshake();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
